ibex_wb_sequencer: RTL and testbench
====================================

Name: ibex_wb_sequencer

Overview:
Writeback stage directly upstream of the register file. It accepts ALU and LSU results over valid/ready handshakes and buffers one result per source. It then sequences each one into the register file's write port: address, data and source select are made stable first, then the write request is strobed, then everything is held. It also exposes a pending-write hazard query for the decode stage.

Parameters:
DataWidth, 32, width of write data
AddrWidth, 5, register address width
SetupCycles, 1, cycles (>=1) address/data/soursel are stable before rf_req_w_o rises
StrobeCycles, 1, cycles (>=1) rf_req_w_o stays high

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  synchronous active-low reset, sampled on rising edge of clk_i
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU holding register empty
alu_waddr_i  in  AddrWidth  ALU destination register
alu_wdata_i  in  DataWidth  ALU result
lsu_valid_i  in  1  LSU load data valid
lsu_ready_o  out  1  LSU holding register empty
lsu_waddr_i  in  AddrWidth  LSU destination register
lsu_wdata_i  in  DataWidth  LSU load data
rf_req_w_o  out  1  register file write request
rf_waddr_o  out  AddrWidth  register file write address
rf_wdata_alu_o  out  DataWidth  ALU-side write data
rf_wdata_lsu_o  out  DataWidth  LSU-side write data
rf_soursel_o  out  1  0 = ALU data, 1 = LSU data
chk_addr_i  in  AddrWidth  hazard query address
chk_hit_o  out  1  a pending or in-flight write targets chk_addr_i
wb_busy_o  out  1  any result held or write in flight

Behaviour:
- Reset (rst_ni=0 at edge):
  - State IDLE; both holding registers empty.
  - All rf_* outputs 0; counter 0.
  - While rst_ni=0, alu_ready_o and lsu_ready_o are forced 0 and no capture occurs.
- Reset mid-write: rf_req_w_o drops at that edge. The write is abandoned, not replayed.
- Ready generation:
  - ready_o = ~full for each source. It is a registered flag with no combinational path from valid_i.
  - A transfer occurs on a rising edge with valid=1 and ready=1.
- x0 handling: a transfer with waddr=0 is accepted and discarded. The holding register is not loaded and ready stays 1.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If either holding register is full, select a source; LSU has priority when both are full.
  - Latch rf_waddr_o, rf_soursel_o and the selected rf_wdata_*_o. The unselected data output keeps its prior value.
  - Clear that holding register, so its ready is 1 next cycle. Load the counter and go to SETUP.
- SETUP: rf_req_w_o=0 for SetupCycles cycles, then go to STROBE.
- STROBE: rf_req_w_o=1 for StrobeCycles cycles, then go to HOLD.
- HOLD:
  - rf_req_w_o=0 for 1 cycle, with all rf_* outputs unchanged.
  - Then, if a holding register is full, perform the IDLE latch action and go to SETUP; else go to IDLE.
- Latency and throughput:
  - Write period = SetupCycles+StrobeCycles+1 cycles back-to-back (3 at defaults).
  - From accept to first rf_req_w_o high: 1+SetupCycles cycles from IDLE.
- rf_* outputs change only on the latch edge. They are never modified in SETUP, STROBE or HOLD.
- Holding register capture and drain: a register that is full cannot accept a new result. Its ready=0 prevents this, so capture and drain in the same cycle cannot collide.
- The other source may capture while a write is in flight.
- chk_hit_o (combinational) = chk_addr_i!=0 AND any of:
  - ALU holding register full with a matching address;
  - LSU holding register full with a matching address;
  - state!=IDLE with rf_waddr_o==chk_addr_i.
- wb_busy_o = state!=IDLE | alu_full | lsu_full.

Decomposition:
- Package ibex_wb_pkg:
  - wb_state_e {IDLE, SETUP, STROBE, HOLD};
  - wb_src_e {SRC_ALU=0, SRC_LSU=1};
  - wb_req_t struct {waddr, wdata};
  - counter width constant derived from max(SetupCycles, StrobeCycles).
- Sub-module ibex_wb_hold_reg, instantiated twice (one per source):
  - valid/ready capture with x0 discard and clear input;
  - full flag and wb_req_t out.

Test Plan:
1. Reset: hold rst_ni=0 for 3 cycles with alu_valid_i=1 -> readys 0, rf_req_w_o=0, rf outputs 0, no capture; after release alu_ready_o=1.
2. Single ALU write: alu waddr=4, wdata=1 accepted at cycle 0 -> waddr=4 and soursel=0 latched at cycle 1; rf_req_w_o high exactly in cycle 2; outputs stable through cycle 3; IDLE after.
3. Simultaneous ALU(5, 0xA) and LSU(6, 0xB) in the same cycle -> LSU written first (soursel=1, waddr=6), ALU 3 cycles later (waddr=5); alu_ready_o=0 until the ALU latch.
4. x0 discard: ALU waddr=0, wdata=0xFF -> accepted, no rf_req_w_o pulse, wb_busy_o stays 0.
5. Hazard query: LSU waddr=7 held while a write to 3 is in flight -> chk_hit_o=1 for addr 7 and 3, 0 for 9, and 0 for addr 0 always.
6. Reset during STROBE, then SetupCycles=2, StrobeCycles=3 -> on reset rf_req_w_o low next edge and the write is dropped; after reset, req high for exactly 3 cycles after 2 setup cycles.

Source files
------------

// File: rtl/ibex_wb_pkg.sv
// rtl/ibex_wb_pkg.sv - shared types and helpers for the writeback sequencer
package ibex_wb_pkg;

  localparam int unsigned WbAddrWidth = 5;
  localparam int unsigned WbDataWidth = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } wb_state_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [WbAddrWidth-1:0] waddr;
    logic [WbDataWidth-1:0] wdata;
  } wb_req_t;

  // Phase counter counts down from (cycles-1), so it must hold max(setup, strobe)-1.
  function automatic int unsigned wb_cnt_width(input int unsigned setup, input int unsigned strobe);
    int unsigned m;
    m = (setup > strobe) ? setup : strobe;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ibex_wb_hold_reg.sv
// rtl/ibex_wb_hold_reg.sv - one-entry result buffer with x0 discard and drain clear
module ibex_wb_hold_reg
  import ibex_wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    valid,
  output logic    ready,
  input  wb_req_t req,
  input  logic    clear,
  output logic    full,
  output wb_req_t held
);

  logic    full_q;
  wb_req_t req_q;

  // Clear only arrives while full and capture only while empty, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else if (clear) begin
      full_q <= 1'b0;
    end else if (valid && !full_q && (req.waddr != '0)) begin
      full_q <= 1'b1;
      req_q  <= req;
    end
  end

  assign ready = rst_n & ~full_q;
  assign full  = full_q;
  assign held  = req_q;

endmodule

// File: rtl/ibex_wb_sequencer.sv
// rtl/ibex_wb_sequencer.sv - writeback sequencer driving the register file write port
module ibex_wb_sequencer
  import ibex_wb_pkg::*;
#(
  parameter int unsigned DataWidth    = WbDataWidth,
  parameter int unsigned AddrWidth    = WbAddrWidth,
  parameter int unsigned SetupCycles  = 1,
  parameter int unsigned StrobeCycles = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [AddrWidth-1:0] alu_waddr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [AddrWidth-1:0] lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_req_w_o,
  output logic [AddrWidth-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_alu_o,
  output logic [DataWidth-1:0] rf_wdata_lsu_o,
  output logic                 rf_soursel_o,
  input  logic [AddrWidth-1:0] chk_addr_i,
  output logic                 chk_hit_o,
  output logic                 wb_busy_o
);

  localparam int unsigned CntW = wb_cnt_width(SetupCycles, StrobeCycles);

  wb_req_t   alu_req, lsu_req, alu_held, lsu_held;
  logic      alu_full, lsu_full, alu_clear, lsu_clear;
  wb_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic      latch;
  wb_src_e   sel_src;

  assign alu_req.waddr = WbAddrWidth'(alu_waddr_i);
  assign alu_req.wdata = WbDataWidth'(alu_wdata_i);
  assign lsu_req.waddr = WbAddrWidth'(lsu_waddr_i);
  assign lsu_req.wdata = WbDataWidth'(lsu_wdata_i);

  ibex_wb_hold_reg u_alu_hold (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .valid (alu_valid_i),
    .ready (alu_ready_o),
    .req   (alu_req),
    .clear (alu_clear),
    .full  (alu_full),
    .held  (alu_held)
  );

  ibex_wb_hold_reg u_lsu_hold (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .valid (lsu_valid_i),
    .ready (lsu_ready_o),
    .req   (lsu_req),
    .clear (lsu_clear),
    .full  (lsu_full),
    .held  (lsu_held)
  );

  // HOLD behaves like IDLE on its last cycle so back-to-back writes need no idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    sel_src = lsu_full ? SRC_LSU : SRC_ALU;
    case (state_q)
      IDLE, HOLD: begin
        if (alu_full || lsu_full) begin
          latch   = 1'b1;
          state_d = SETUP;
          cnt_d   = CntW'(SetupCycles - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CntW'(StrobeCycles - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_clear = latch & (sel_src == SRC_ALU);
  assign lsu_clear = latch & (sel_src == SRC_LSU);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The unselected data lane keeps its old value; only the latch edge touches rf_*.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_waddr_o     <= '0;
      rf_wdata_alu_o <= '0;
      rf_wdata_lsu_o <= '0;
      rf_soursel_o   <= 1'b0;
    end else if (latch) begin
      rf_soursel_o <= (sel_src == SRC_LSU);
      if (sel_src == SRC_LSU) begin
        rf_waddr_o     <= AddrWidth'(lsu_held.waddr);
        rf_wdata_lsu_o <= DataWidth'(lsu_held.wdata);
      end else begin
        rf_waddr_o     <= AddrWidth'(alu_held.waddr);
        rf_wdata_alu_o <= DataWidth'(alu_held.wdata);
      end
    end
  end

  assign rf_req_w_o = (state_q == STROBE);

  assign chk_hit_o = (chk_addr_i != '0) &&
                     ((alu_full && (alu_held.waddr == WbAddrWidth'(chk_addr_i))) ||
                      (lsu_full && (lsu_held.waddr == WbAddrWidth'(chk_addr_i))) ||
                      ((state_q != IDLE) && (rf_waddr_o == chk_addr_i)));

  assign wb_busy_o = (state_q != IDLE) | alu_full | lsu_full;

endmodule

// File: tb/tb_ibex_wb_sequencer.sv
// tb/tb_ibex_wb_sequencer.sv - directed table-driven bench for ibex_wb_sequencer
module tb_ibex_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        av, lv;
  logic [4:0]  aw, lw, ca;
  logic [31:0] ad, ld;
  logic        ar, lr, req, sel, hit, busy;
  logic [4:0]  wa;
  logic [31:0] wda, wdl;

  logic        rst2_n;
  logic        a2v;
  logic [4:0]  a2w;
  logic [31:0] a2d;
  logic        l2v;
  logic [4:0]  l2w, ca2;
  logic [31:0] l2d;
  logic        ar2, lr2, req2, sel2, hit2, busy2;
  logic [4:0]  wa2;
  logic [31:0] wda2, wdl2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_wb_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_valid_i(av), .alu_ready_o(ar), .alu_waddr_i(aw), .alu_wdata_i(ad),
    .lsu_valid_i(lv), .lsu_ready_o(lr), .lsu_waddr_i(lw), .lsu_wdata_i(ld),
    .rf_req_w_o(req), .rf_waddr_o(wa), .rf_wdata_alu_o(wda), .rf_wdata_lsu_o(wdl),
    .rf_soursel_o(sel), .chk_addr_i(ca), .chk_hit_o(hit), .wb_busy_o(busy)
  );

  ibex_wb_sequencer #(.SetupCycles(2), .StrobeCycles(3)) dut2 (
    .clk_i(clk), .rst_ni(rst2_n),
    .alu_valid_i(a2v), .alu_ready_o(ar2), .alu_waddr_i(a2w), .alu_wdata_i(a2d),
    .lsu_valid_i(l2v), .lsu_ready_o(lr2), .lsu_waddr_i(l2w), .lsu_wdata_i(l2d),
    .rf_req_w_o(req2), .rf_waddr_o(wa2), .rf_wdata_alu_o(wda2), .rf_wdata_lsu_o(wdl2),
    .rf_soursel_o(sel2), .chk_addr_i(ca2), .chk_hit_o(hit2), .wb_busy_o(busy2)
  );

  typedef struct {
    logic        av;
    logic [4:0]  aw;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lw;
    logic [31:0] ld;
    logic [4:0]  ca;
    logic        e_ar, e_lr, e_req;
    logic [4:0]  e_wa;
    logic        e_sel;
    logic [31:0] e_wda, e_wdl;
    logic        e_busy, e_hit;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic i_av, input logic [4:0] i_aw, input logic [31:0] i_ad,
                              input logic i_lv, input logic [4:0] i_lw, input logic [31:0] i_ld,
                              input logic [4:0] i_ca, input logic x_ar, input logic x_lr,
                              input logic x_req, input logic [4:0] x_wa, input logic x_sel,
                              input logic [31:0] x_wda, input logic [31:0] x_wdl,
                              input logic x_busy, input logic x_hit);
    vec_t v;
    v.av = i_av; v.aw = i_aw; v.ad = i_ad; v.lv = i_lv; v.lw = i_lw; v.ld = i_ld; v.ca = i_ca;
    v.e_ar = x_ar; v.e_lr = x_lr; v.e_req = x_req; v.e_wa = x_wa; v.e_sel = x_sel;
    v.e_wda = x_wda; v.e_wdl = x_wdl; v.e_busy = x_busy; v.e_hit = x_hit;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int highs;
    logic exp_req;
    logic exp_busy;

    // Row: alu in, lsu in, chk addr | ar lr req waddr sel wdata_alu wdata_lsu busy hit
    tbl[0]  = mk(1, 4, 32'h1,  0, 0, 0,     4, 0, 1, 0, 4'd0, 0, 32'h0,  32'h0,  1, 1);
    tbl[1]  = mk(0, 0, 0,      0, 0, 0,     4, 1, 1, 0, 5'd4, 0, 32'h1,  32'h0,  1, 1);
    tbl[2]  = mk(0, 0, 0,      0, 0, 0,     4, 1, 1, 1, 5'd4, 0, 32'h1,  32'h0,  1, 1);
    tbl[3]  = mk(0, 0, 0,      0, 0, 0,     4, 1, 1, 0, 5'd4, 0, 32'h1,  32'h0,  1, 1);
    tbl[4]  = mk(0, 0, 0,      0, 0, 0,     4, 1, 1, 0, 5'd4, 0, 32'h1,  32'h0,  0, 0);
    tbl[5]  = mk(1, 5, 32'hA,  1, 6, 32'hB, 5, 0, 0, 0, 5'd4, 0, 32'h1,  32'h0,  1, 1);
    tbl[6]  = mk(0, 0, 0,      0, 0, 0,     5, 0, 1, 0, 5'd6, 1, 32'h1,  32'hB,  1, 1);
    tbl[7]  = mk(0, 0, 0,      0, 0, 0,     5, 0, 1, 1, 5'd6, 1, 32'h1,  32'hB,  1, 1);
    tbl[8]  = mk(0, 0, 0,      0, 0, 0,     5, 0, 1, 0, 5'd6, 1, 32'h1,  32'hB,  1, 1);
    tbl[9]  = mk(0, 0, 0,      0, 0, 0,     5, 1, 1, 0, 5'd5, 0, 32'hA,  32'hB,  1, 1);
    tbl[10] = mk(0, 0, 0,      0, 0, 0,     5, 1, 1, 1, 5'd5, 0, 32'hA,  32'hB,  1, 1);
    tbl[11] = mk(0, 0, 0,      0, 0, 0,     5, 1, 1, 0, 5'd5, 0, 32'hA,  32'hB,  1, 1);
    tbl[12] = mk(0, 0, 0,      0, 0, 0,     5, 1, 1, 0, 5'd5, 0, 32'hA,  32'hB,  0, 0);
    tbl[13] = mk(1, 0, 32'hFF, 0, 0, 0,     0, 1, 1, 0, 5'd5, 0, 32'hA,  32'hB,  0, 0);
    tbl[14] = mk(0, 0, 0,      0, 0, 0,     0, 1, 1, 0, 5'd5, 0, 32'hA,  32'hB,  0, 0);
    tbl[15] = mk(0, 0, 0,      0, 0, 0,     0, 1, 1, 0, 5'd5, 0, 32'hA,  32'hB,  0, 0);
    tbl[16] = mk(1, 3, 32'h3C, 0, 0, 0,     3, 0, 1, 0, 5'd5, 0, 32'hA,  32'hB,  1, 1);
    tbl[17] = mk(0, 0, 0,      1, 7, 32'h77,7, 1, 0, 0, 5'd3, 0, 32'h3C, 32'hB,  1, 1);
    tbl[18] = mk(0, 0, 0,      0, 0, 0,     3, 1, 0, 1, 5'd3, 0, 32'h3C, 32'hB,  1, 1);
    tbl[19] = mk(0, 0, 0,      0, 0, 0,     9, 1, 0, 0, 5'd3, 0, 32'h3C, 32'hB,  1, 0);
    tbl[20] = mk(0, 0, 0,      0, 0, 0,     0, 1, 1, 0, 5'd7, 1, 32'h3C, 32'h77, 1, 0);
    tbl[21] = mk(0, 0, 0,      0, 0, 0,     7, 1, 1, 1, 5'd7, 1, 32'h3C, 32'h77, 1, 1);
    tbl[22] = mk(0, 0, 0,      0, 0, 0,     3, 1, 1, 0, 5'd7, 1, 32'h3C, 32'h77, 1, 0);
    tbl[23] = mk(0, 0, 0,      0, 0, 0,     7, 1, 1, 0, 5'd7, 1, 32'h3C, 32'h77, 0, 0);

    rst_n = 1'b0; av = 1'b1; aw = 5'd4; ad = 32'h1; lv = 1'b0; lw = '0; ld = '0; ca = '0;
    rst2_n = 1'b0; a2v = 1'b0; a2w = '0; a2d = '0; l2v = 1'b0; l2w = '0; l2d = '0; ca2 = '0;

    // Reset holds off capture even with valid asserted
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d_alu_ready", i), {31'b0, ar}, 32'd0);
      check($sformatf("rst%0d_lsu_ready", i), {31'b0, lr}, 32'd0);
      check($sformatf("rst%0d_req", i), {31'b0, req}, 32'd0);
      check($sformatf("rst%0d_rf", i), {wa, sel, wda[25:0]} | wdl, 32'd0);
      check($sformatf("rst%0d_busy", i), {31'b0, busy}, 32'd0);
    end
    av = 1'b0;
    rst_n = 1'b1;
    #1;
    check("release_alu_ready", {31'b0, ar}, 32'd1);

    for (int i = 0; i < 24; i++) begin
      av = tbl[i].av; aw = tbl[i].aw; ad = tbl[i].ad;
      lv = tbl[i].lv; lw = tbl[i].lw; ld = tbl[i].ld; ca = tbl[i].ca;
      @(posedge clk); #1;
      check($sformatf("row%0d_alu_ready", i), {31'b0, ar}, {31'b0, tbl[i].e_ar});
      check($sformatf("row%0d_lsu_ready", i), {31'b0, lr}, {31'b0, tbl[i].e_lr});
      check($sformatf("row%0d_req", i), {31'b0, req}, {31'b0, tbl[i].e_req});
      check($sformatf("row%0d_waddr", i), {27'b0, wa}, {27'b0, tbl[i].e_wa});
      check($sformatf("row%0d_soursel", i), {31'b0, sel}, {31'b0, tbl[i].e_sel});
      check($sformatf("row%0d_wdata_alu", i), wda, tbl[i].e_wda);
      check($sformatf("row%0d_wdata_lsu", i), wdl, tbl[i].e_wdl);
      check($sformatf("row%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
      check($sformatf("row%0d_hit", i), {31'b0, hit}, {31'b0, tbl[i].e_hit});
    end
    av = 1'b0; lv = 1'b0;

    // Second instance: SetupCycles=2, StrobeCycles=3; reset during STROBE abandons the write
    rst2_n = 1'b1;
    @(posedge clk); #1;
    a2v = 1'b1; a2w = 5'd8; a2d = 32'h5;
    @(posedge clk); #1;
    a2v = 1'b0;
    check("p2_accept_busy", {31'b0, busy2}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("p2_pre%0d_req", i), {31'b0, req2}, (i == 3) ? 32'd1 : 32'd0);
    end
    rst2_n = 1'b0;
    @(posedge clk); #1;
    check("p2_rst_req", {31'b0, req2}, 32'd0);
    check("p2_rst_busy", {31'b0, busy2}, 32'd0);
    check("p2_rst_waddr", {27'b0, wa2}, 32'd0);
    rst2_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("p2_noreplay%0d_req", i), {31'b0, req2}, 32'd0);
      check($sformatf("p2_noreplay%0d_busy", i), {31'b0, busy2}, 32'd0);
    end

    a2v = 1'b1; a2w = 5'd9; a2d = 32'h99;
    @(posedge clk); #1;
    a2v = 1'b0;
    highs = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      exp_req  = (i >= 3) && (i <= 5);
      exp_busy = (i <= 6);
      if (req2) highs++;
      check($sformatf("p2_seq%0d_req", i), {31'b0, req2}, {31'b0, exp_req});
      check($sformatf("p2_seq%0d_busy", i), {31'b0, busy2}, {31'b0, exp_busy});
    end
    check("p2_strobe_len", highs, 32'd3);
    check("p2_waddr", {27'b0, wa2}, 32'd9);
    check("p2_wdata_alu", wda2, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
